control_sequencer: RTL

- Control-step state machine that directly feeds the ALU stage.
- Drives the 5-bit ALU opCode and all datapath strobes (PC/MAR/MDR/IR/Y/Z/HI/LO/register-file select) through fetch and execute steps T0..T6.
- Scope: register, immediate, unary and mul/div ALU instructions, plus nop and halt. Load/store/branch are out of scope and trap as illegal.
- Outputs are Moore-style: decoded from the state register and the latched IR opcode only.

---
 rtl/cpu_ctrl_pkg.sv | 125 ++++++++++++
 rtl/op_class_decode.sv | 36 +++
 rtl/control_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_ctrl_pkg : opcodes, state/op-class enums and step strobe decode  |
// | Revision 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package cpu_ctrl_pkg;

  // Opcode values shared with the ALU stage
  localparam logic [4:0] c_OP_ADD  = 5'b00011;
  localparam logic [4:0] c_OP_SUB  = 5'b00100;
  localparam logic [4:0] c_OP_AND  = 5'b00101;
  localparam logic [4:0] c_OP_OR   = 5'b00110;
  localparam logic [4:0] c_OP_SHR  = 5'b00111;
  localparam logic [4:0] c_OP_SHRA = 5'b01000;
  localparam logic [4:0] c_OP_SHL  = 5'b01001;
  localparam logic [4:0] c_OP_ROR  = 5'b01010;
  localparam logic [4:0] c_OP_ROL  = 5'b01011;
  localparam logic [4:0] c_OP_ADDI = 5'b01100;
  localparam logic [4:0] c_OP_ANDI = 5'b01101;
  localparam logic [4:0] c_OP_ORI  = 5'b01110;
  localparam logic [4:0] c_OP_MUL  = 5'b01111;
  localparam logic [4:0] c_OP_DIV  = 5'b10000;
  localparam logic [4:0] c_OP_NEG  = 5'b10001;
  localparam logic [4:0] c_OP_NOT  = 5'b10010;
  localparam logic [4:0] c_OP_NOP  = 5'b11010;
  localparam logic [4:0] c_OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
`ifdef SINGLE_STEP_EN
    , STEP_WAIT = 4'd9
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_U       = 3'd2,
    CLS_MD      = 3'd3,
    CLS_NOP     = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } opclass_t;

  typedef struct packed {
    logic pcOut;
    logic marIn;
    logic incPc;
    logic pcIn;
    logic memRead;
    logic mdrIn;
    logic mdrOut;
    logic irIn;
    logic yIn;
    logic zIn;
    logic zlowOut;
    logic zhighOut;
    logic hiIn;
    logic loIn;
    logic gra;
    logic grb;
    logic grc;
    logic rIn;
    logic rOut;
    logic cOut;
    logic done;
    logic illegal;
  } strobes_t;

  // Strobe set to present while sitting in state st for an instruction of class cls
  function automatic strobes_t stepStrobes(state_t st, opclass_t cls);
    strobes_t s;
    s = '0;
    case (st)
      T0: begin s.pcOut = 1'b1; s.marIn = 1'b1; s.incPc = 1'b1; s.zIn = 1'b1; end
      T1: begin s.zlowOut = 1'b1; s.pcIn = 1'b1; s.memRead = 1'b1; s.mdrIn = 1'b1; end
      T2: begin s.mdrOut = 1'b1; s.irIn = 1'b1; end
      T3: begin
        case (cls)
          CLS_R, CLS_I: begin s.grb = 1'b1; s.rOut = 1'b1; s.yIn = 1'b1; end
          CLS_U:        begin s.grb = 1'b1; s.rOut = 1'b1; s.zIn = 1'b1; end
          CLS_MD:       begin s.gra = 1'b1; s.rOut = 1'b1; s.yIn = 1'b1; end
          CLS_ILLEGAL:  s.illegal = 1'b1;
          default:      ;
        endcase
      end
      T4: begin
        case (cls)
          CLS_R:   begin s.grc = 1'b1; s.rOut = 1'b1; s.zIn = 1'b1; end
          CLS_I:   begin s.cOut = 1'b1; s.zIn = 1'b1; end
          CLS_U:   begin s.zlowOut = 1'b1; s.gra = 1'b1; s.rIn = 1'b1; end
          CLS_MD:  begin s.grb = 1'b1; s.rOut = 1'b1; s.zIn = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CLS_R, CLS_I: begin s.zlowOut = 1'b1; s.gra = 1'b1; s.rIn = 1'b1; end
          CLS_MD:       begin s.zlowOut = 1'b1; s.loIn = 1'b1; end
          default:      ;
        endcase
      end
      T6:      begin s.zhighOut = 1'b1; s.hiIn = 1'b1; end
      HALT:    s.done = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

  // The ALU sees the opcode only in the step that loads Z with its result
  function automatic logic aluActive(state_t st, opclass_t cls);
    return ((st == T3) && (cls == CLS_U)) ||
           ((st == T4) && ((cls == CLS_R) || (cls == CLS_I) || (cls == CLS_MD)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/op_class_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | op_class_decode : combinational opcode to instruction-class decoder  |
// | Revision 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module op_class_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int              OP_W    = 5,
  parameter logic [OP_W-1:0] NOP_OP  = 5'b11010,
  parameter logic [OP_W-1:0] HALT_OP = 5'b11011
) (
  input  logic [OP_W-1:0] i_opcode,
  output opclass_t        o_opClass
);

  always_comb begin
    o_opClass = CLS_ILLEGAL;
    if (i_opcode == NOP_OP) begin
      o_opClass = CLS_NOP;
    end else if (i_opcode == HALT_OP) begin
      o_opClass = CLS_HALT;
    end else begin
      case (i_opcode)
        c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHR,
        c_OP_SHRA, c_OP_SHL, c_OP_ROR, c_OP_ROL:  o_opClass = CLS_R;
        c_OP_ADDI, c_OP_ANDI, c_OP_ORI:           o_opClass = CLS_I;
        c_OP_NEG, c_OP_NOT:                       o_opClass = CLS_U;
        c_OP_MUL, c_OP_DIV:                       o_opClass = CLS_MD;
        default:                                  o_opClass = CLS_ILLEGAL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_sequencer : T0..T6 control-step FSM driving ALU and strobes  |
// | Optional macro SINGLE_STEP_EN adds the STEP_WAIT single-step state.  |
// | Revision 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int              DATA_W  = 32,
  parameter int              OP_W    = 5,
  parameter logic [OP_W-1:0] NOP_OP  = 5'b11010,
  parameter logic [OP_W-1:0] HALT_OP = 5'b11011
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              run,
  input  logic [DATA_W-1:0] ir,
  input  logic              step,
  output logic [OP_W-1:0]   alu_op,
  output logic              pc_out,
  output logic              mar_in,
  output logic              inc_pc,
  output logic              pc_in,
  output logic              mem_read,
  output logic              mdr_in,
  output logic              mdr_out,
  output logic              ir_in,
  output logic              y_in,
  output logic              z_in,
  output logic              zlow_out,
  output logic              zhigh_out,
  output logic              hi_in,
  output logic              lo_in,
  output logic              gra,
  output logic              grb,
  output logic              grc,
  output logic              r_in,
  output logic              r_out,
  output logic              c_out,
  output logic              done,
  output logic              illegal,
  output logic [3:0]        step_state
);

  state_t            r_state;
  opclass_t          r_class;
  logic [OP_W-1:0]   r_opcode;
  strobes_t          r_strobes;
  logic [OP_W-1:0]   r_aluOp;

  logic [OP_W-1:0]   w_opcode;
  opclass_t          w_decClass;
  logic              w_latch;
  opclass_t          w_nextClass;
  logic [OP_W-1:0]   w_nextOp;
  state_t            w_endState;
  state_t            w_nextState;
  strobes_t          w_nextStrobes;
  logic              w_unusedBits;

  assign w_opcode = ir[DATA_W-1 -: OP_W];

  op_class_decode #(
    .OP_W    (OP_W),
    .NOP_OP  (NOP_OP),
    .HALT_OP (HALT_OP)
  ) u_decode (
    .i_opcode  (w_opcode),
    .o_opClass (w_decClass)
  );

  // IR is captured on the T2->T3 edge so T3 strobes already reflect the new class
  assign w_latch     = (r_state == T2);
  assign w_nextClass = w_latch ? w_decClass : r_class;
  assign w_nextOp    = w_latch ? w_opcode   : r_opcode;

`ifdef SINGLE_STEP_EN
  assign w_endState   = STEP_WAIT;
  assign w_unusedBits = ^ir[DATA_W-OP_W-1:0];
`else
  assign w_endState   = run ? T0 : IDLE;
  assign w_unusedBits = ^{ir[DATA_W-OP_W-1:0], step};
`endif

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (run) w_nextState = T0;
      T0:   w_nextState = T1;
      T1:   w_nextState = T2;
      T2:   w_nextState = T3;
      T3: begin
        case (r_class)
          CLS_HALT:                    w_nextState = HALT;
          CLS_R, CLS_I, CLS_U, CLS_MD: w_nextState = T4;
          default:                     w_nextState = w_endState;
        endcase
      end
      T4: begin
        if (r_class == CLS_U) w_nextState = w_endState;
        else                  w_nextState = T5;
      end
      T5: begin
        if (r_class == CLS_MD) w_nextState = T6;
        else                   w_nextState = w_endState;
      end
      T6:   w_nextState = w_endState;
      HALT: w_nextState = HALT;
`ifdef SINGLE_STEP_EN
      STEP_WAIT: begin
        if (!run)     w_nextState = IDLE;
        else if (step) w_nextState = T0;
      end
`endif
      default: w_nextState = IDLE;
    endcase
  end

  assign w_nextStrobes = stepStrobes(w_nextState, w_nextClass);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= IDLE;
      r_class   <= CLS_NOP;
      r_opcode  <= '0;
      r_strobes <= '0;
      r_aluOp   <= '0;
    end else begin
      r_state   <= w_nextState;
      r_strobes <= w_nextStrobes;
      r_aluOp   <= aluActive(w_nextState, w_nextClass) ? w_nextOp : '0;
      if (w_latch) begin
        r_class  <= w_decClass;
        r_opcode <= w_opcode;
      end
    end
  end

  assign alu_op     = r_aluOp;
  assign pc_out     = r_strobes.pcOut;
  assign mar_in     = r_strobes.marIn;
  assign inc_pc     = r_strobes.incPc;
  assign pc_in      = r_strobes.pcIn;
  assign mem_read   = r_strobes.memRead;
  assign mdr_in     = r_strobes.mdrIn;
  assign mdr_out    = r_strobes.mdrOut;
  assign ir_in      = r_strobes.irIn;
  assign y_in       = r_strobes.yIn;
  assign z_in       = r_strobes.zIn;
  assign zlow_out   = r_strobes.zlowOut;
  assign zhigh_out  = r_strobes.zhighOut;
  assign hi_in      = r_strobes.hiIn;
  assign lo_in      = r_strobes.loIn;
  assign gra        = r_strobes.gra;
  assign grb        = r_strobes.grb;
  assign grc        = r_strobes.grc;
  assign r_in       = r_strobes.rIn;
  assign r_out      = r_strobes.rOut;
  assign c_out      = r_strobes.cOut;
  assign done       = r_strobes.done;
  assign illegal    = r_strobes.illegal;
  assign step_state = r_state;

endmodule
`default_nettype wire
